riscv_soc_top: RTL and testbench

//  Board-level top for the Arty S7 bring-up image: a heartbeat LED and a tiny
//  ROM-driven micro-sequencer that drives three GPIO pins (D1..D3).

---
 rtl/riscv_soc_top.sv | 114 +++++++++++
 tb/tb_riscv_soc_top.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_soc_top.sv
// Board top for bring-up: heartbeat LED plus a ROM-driven GPIO micro-sequencer (optional macro HEARTBEAT_EN).
// Latency: one instruction per clk edge; WAIT n stalls n edges; all outputs registered.
// Backpressure: none, the sequencer is free-running with no handshake.
module riscv_soc_top #(
    parameter int HB_DIV_LOG2 = 4,
    parameter int ROM_DEPTH   = 16,
    parameter int WAIT_W      = 12,
    parameter logic [ROM_DEPTH*16-1:0] ROM_INIT = {
        {9{16'hC000}},
        16'h8000,
        16'h400A,
        16'h0004,
        16'h400A,
        16'h0002,
        16'h400A,
        16'h0001
    }
) (
    input  logic clk,
    input  logic resetn,
    output logic led_green,
    output logic D1,
    output logic D2,
    output logic D3
);

    localparam int PC_W = $clog2(ROM_DEPTH);

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    logic [PC_W-1:0]   pc;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        pattern;
    logic              halted;

    logic [1:0]        op;
    logic [WAIT_W-1:0] imm;
    logic [PC_W-1:0]   target;
    logic [2:0]        set_val;
    logic              exec;

    // Fields are sliced straight out of the ROM word at the current pc.
    always_comb begin
        op      = ROM_INIT[{pc, 4'd14} +: 2];
        imm     = ROM_INIT[{pc, 4'd0} +: WAIT_W];
        target  = ROM_INIT[{pc, 4'd0} +: PC_W];
        set_val = ROM_INIT[{pc, 4'd0} +: 3];
        exec    = !halted && (wait_cnt == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc       <= '0;
            wait_cnt <= '0;
            pattern  <= 3'b000;
            halted   <= 1'b0;
        end else if (halted) begin
            pc       <= pc;
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end else begin
            case (op)
                OP_SET: begin
                    pattern <= set_val;
                    pc      <= pc + PC_W'(1);
                end
                OP_WAIT: begin
                    // The WAIT edge itself counts as the first of its n edges.
                    wait_cnt <= (imm == '0) ? '0 : imm - WAIT_W'(1);
                    pc       <= pc + PC_W'(1);
                end
                OP_JUMP: begin
                    pc <= target;
                end
                default: begin
                    halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef HEARTBEAT_EN
    logic [HB_DIV_LOG2-1:0] hb_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hb_cnt    <= '0;
            led_green <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + HB_DIV_LOG2'(1);
            if (hb_cnt == '1) begin
                led_green <= ~led_green;
            end
        end
    end
`else
    // Run indicator drops on the very edge that executes HALT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_green <= 1'b0;
        end else begin
            led_green <= ~(halted || (exec && (op == OP_HALT)));
        end
    end
`endif

    assign D1 = pattern[0];
    assign D2 = pattern[1];
    assign D3 = pattern[2];

endmodule

// File: tb/tb_riscv_soc_top.sv
// Bench for riscv_soc_top: three ROM images run side by side against an instruction-level program model.
module tb_riscv_soc_top;

    localparam int NP   = 3;
    localparam int MAXN = 4200;
    localparam int HB   = 4;

    localparam logic [255:0] ROM_DEF = {{9{16'hC000}}, 16'h8000, 16'h400A, 16'h0004,
                                        16'h400A, 16'h0002, 16'h400A, 16'h0001};
    localparam logic [255:0] ROM_HLT = {{15{16'hC000}}, 16'h0007};
    localparam logic [255:0] ROM_W0  = {{10{16'hC000}}, 16'h8002, 16'h0006, 16'h4003,
                                        16'h0005, 16'h4000, 16'h0003};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [NP-1:0] led, d1, d2, d3;

    int compared = 0;
    int mismatched = 0;
    int n = 0;

    logic [2:0] exp_pat [NP][MAXN+1];
    logic       exp_hlt [NP][MAXN+1];

    initial forever #5 clk = ~clk;

    riscv_soc_top dut0 (
        .clk(clk), .resetn(resetn), .led_green(led[0]), .D1(d1[0]), .D2(d2[0]), .D3(d3[0])
    );
    riscv_soc_top #(.ROM_INIT(ROM_HLT)) dut1 (
        .clk(clk), .resetn(resetn), .led_green(led[1]), .D1(d1[1]), .D2(d2[1]), .D3(d3[1])
    );
    riscv_soc_top #(.ROM_INIT(ROM_W0)) dut2 (
        .clk(clk), .resetn(resetn), .led_green(led[2]), .D1(d1[2]), .D2(d2[2]), .D3(d3[2])
    );

    function automatic logic [255:0] rom_of(input int p);
        if (p == 0) return ROM_DEF;
        if (p == 1) return ROM_HLT;
        return ROM_W0;
    endfunction

    // Interprets the program one instruction at a time, noting the edge each one lands on.
    task automatic build_model(input int p);
        logic [255:0] rom;
        logic [15:0]  w;
        logic [2:0]   pat;
        logic         hlt;
        int           pc;
        int           next_exec;
        rom = rom_of(p);
        pat = 3'b000;
        hlt = 1'b0;
        pc = 0;
        next_exec = 1;
        exp_pat[p][0] = 3'b000;
        exp_hlt[p][0] = 1'b0;
        for (int e = 1; e <= MAXN; e++) begin
            if (!hlt && e == next_exec) begin
                w = rom[pc*16 +: 16];
                case (w[15:14])
                    2'b00: begin pat = w[2:0]; pc = (pc + 1) % 16; next_exec = e + 1; end
                    2'b01: begin
                        pc = (pc + 1) % 16;
                        next_exec = e + ((w[11:0] == 12'd0) ? 1 : int'(w[11:0]));
                    end
                    2'b10: begin pc = int'(w[3:0]); next_exec = e + 1; end
                    default: hlt = 1'b1;
                endcase
            end
            exp_pat[p][e] = pat;
            exp_hlt[p][e] = hlt;
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp_v);
        end
    endtask

    function automatic logic exp_led(input int p, input int k, output logic skip);
        skip = 1'b0;
`ifdef HEARTBEAT_EN
        return 1'((k >> HB) & 1);
`else
        if (k == 0) return 1'b0;
        if (exp_hlt[p][k] && !exp_hlt[p][k-1]) skip = 1'b1;
        return !exp_hlt[p][k];
`endif
    endfunction

    task automatic reset_check();
        for (int p = 0; p < NP; p++) begin
            chk3($sformatf("rst_pat%0d", p), {d3[p], d2[p], d1[p]}, 3'b000);
            chk1($sformatf("rst_led%0d", p), led[p], 1'b0);
        end
    endtask

    task automatic step_check();
        logic el;
        logic skip;
        @(posedge clk);
        n++;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            chk3($sformatf("pat%0d", p), {d3[p], d2[p], d1[p]}, exp_pat[p][n]);
            el = exp_led(p, n, skip);
            if (!skip) chk1($sformatf("led%0d", p), led[p], el);
        end
    endtask

    task automatic async_reset_now();
        resetn = 1'b0;
        #1;
        reset_check();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_check();
        resetn = 1'b1;
        n = 0;
    endtask

    initial begin
        for (int p = 0; p < NP; p++) build_model(p);

        resetn = 1'b0;
        repeat (10) @(posedge clk);
        release_reset();

        for (int i = 0; i < 4000; i++) begin
            step_check();
            if (n == 1)  chk3("def_e1",  {d3[0], d2[0], d1[0]}, 3'b001);
            if (n == 11) chk3("def_e11", {d3[0], d2[0], d1[0]}, 3'b001);
            if (n == 12) chk3("def_e12", {d3[0], d2[0], d1[0]}, 3'b010);
            if (n == 23) chk3("def_e23", {d3[0], d2[0], d1[0]}, 3'b100);
            if (n == 34) chk3("def_e34", {d3[0], d2[0], d1[0]}, 3'b100);
            if (n == 35) chk3("def_e35", {d3[0], d2[0], d1[0]}, 3'b001);
            if (n == 3)  chk3("w0_e3",   {d3[2], d2[2], d1[2]}, 3'b101);
            if (n == 50) chk3("hlt_hold", {d3[1], d2[1], d1[1]}, 3'b111);
`ifdef HEARTBEAT_EN
            if (n == 16) chk1("hb_rise", led[0], 1'b1);
            if (n == 32) chk1("hb_fall", led[0], 1'b0);
`else
            if (n == 1)  chk1("run_led", led[1], 1'b1);
            if (n == 3)  chk1("halt_led", led[1], 1'b0);
`endif
        end

        @(posedge clk);
        #2;
        async_reset_now();
        release_reset();

        repeat (17) step_check();
        #1;
        async_reset_now();
        release_reset();
        step_check();
        chk3("rel_e1", {d3[0], d2[0], d1[0]}, 3'b001);

        repeat (6) begin
            repeat ($urandom_range(1, 300)) step_check();
            @(posedge clk);
            #($urandom_range(1, 3));
            async_reset_now();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            release_reset();
        end
        repeat (40) step_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
